// File: rtl/pwm_ramp_ctrl.sv
// Write-port sequencer for the 8-channel PWM register block: configures every
// channel on start, then slews each duty toward its host target by <= STEP per tick.
module pwm_ramp_ctrl #(
    parameter int unsigned CLK_DIV  = 50000,
    parameter int unsigned PERIOD   = 1000000,
    parameter int unsigned STEP     = 500,
    parameter int unsigned DUTY_RST = 75000,
    parameter int unsigned DMIN     = 50000,
    parameter int unsigned DMAX     = 100000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic        stop,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_ch,
    input  logic [31:0] cmd_target,
    output logic        busy,
    output logic [7:0]  settled,
    output logic        pwm_wr,
    output logic [31:0] pwm_addr,
    output logic [31:0] pwm_data
);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_SCAN, S_DIS} state_t;

    state_t      state, state_nxt;
    logic [2:0]  ch, ch_nxt;
    logic [1:0]  sub, sub_nxt;
    logic [31:0] presc, presc_nxt, presc_inc;
    logic        presc_tc;
    logic        stop_pend, stop_pend_nxt;
    logic [31:0] cur [8];
    logic [31:0] tgt [8];
    logic        wr_nxt;
    logic [31:0] addr_nxt, data_nxt;
    logic        scan_go;
    logic [2:0]  scan_k;
    logic        cur_upd;
    logic [31:0] cur_val;
    logic        cmd_fire;

    function automatic logic [31:0] ch_base(input logic [2:0] n);
        return 32'(n) * 32'd12;
    endfunction

    function automatic logic [31:0] ramp(input logic [31:0] c, input logic [31:0] t);
        logic [31:0] d;
        if (c < t) begin
            d = t - c;
            return (d > STEP) ? c + STEP : t;
        end else begin
            d = c - t;
            return (d > STEP) ? c - STEP : t;
        end
    endfunction

    function automatic logic [31:0] clamp(input logic [31:0] x);
        if (x < DMIN) return DMIN;
        if (x > DMAX) return DMAX;
        return x;
    endfunction

    assign presc_tc  = (presc == CLK_DIV - 1);
    assign presc_inc = presc_tc ? '0 : presc + 32'd1;
    assign cmd_fire  = cmd_valid && cmd_ready;

    // The write for the next cycle is computed one cycle ahead so that pwm_*
    // lines up with the state/slot that owns it.
    always_comb begin
        state_nxt     = state;
        ch_nxt        = ch;
        sub_nxt       = sub;
        presc_nxt     = presc;
        stop_pend_nxt = stop_pend;
        wr_nxt        = 1'b0;
        addr_nxt      = '0;
        data_nxt      = '0;
        scan_go       = 1'b0;
        scan_k        = '0;
        cur_upd       = 1'b0;
        cur_val       = '0;
        case (state)
            S_IDLE: begin
                presc_nxt     = '0;
                stop_pend_nxt = 1'b0;
                if (start) begin
                    state_nxt = S_INIT;
                    ch_nxt    = '0;
                    sub_nxt   = '0;
                    wr_nxt    = 1'b1;
                    addr_nxt  = ch_base(3'd0) + 32'd8;
                    data_nxt  = PERIOD;
                end
            end
            S_INIT: begin
                if (ch == 3'd7 && sub == 2'd2) begin
                    state_nxt = S_RUN;
                    presc_nxt = '0;
                end else begin
                    if (sub == 2'd2) begin
                        ch_nxt  = ch + 3'd1;
                        sub_nxt = '0;
                    end else begin
                        sub_nxt = sub + 2'd1;
                    end
                    wr_nxt = 1'b1;
                    case (sub_nxt)
                        2'd0: begin
                            addr_nxt = ch_base(ch_nxt) + 32'd8;
                            data_nxt = PERIOD;
                        end
                        2'd1: begin
                            addr_nxt = ch_base(ch_nxt) + 32'd4;
                            data_nxt = cur[ch_nxt];
                        end
                        default: begin
                            addr_nxt = ch_base(ch_nxt);
                            data_nxt = 32'd1;
                        end
                    endcase
                end
            end
            S_RUN: begin
                presc_nxt = presc_inc;
                if (stop) begin
                    state_nxt     = S_DIS;
                    ch_nxt        = '0;
                    stop_pend_nxt = 1'b0;
                    wr_nxt        = 1'b1;
                    addr_nxt      = ch_base(3'd0);
                    data_nxt      = '0;
                end else if (presc_tc) begin
                    state_nxt = S_SCAN;
                    ch_nxt    = '0;
                    scan_go   = 1'b1;
                    scan_k    = '0;
                end
            end
            S_SCAN: begin
                presc_nxt = presc_inc;
                if (stop) stop_pend_nxt = 1'b1;
                if (ch == 3'd7) begin
                    if (stop || stop_pend) begin
                        state_nxt     = S_DIS;
                        ch_nxt        = '0;
                        stop_pend_nxt = 1'b0;
                        wr_nxt        = 1'b1;
                        addr_nxt      = ch_base(3'd0);
                        data_nxt      = '0;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end else begin
                    ch_nxt  = ch + 3'd1;
                    scan_go = 1'b1;
                    scan_k  = ch + 3'd1;
                end
            end
            S_DIS: begin
                presc_nxt = '0;
                if (ch == 3'd7) begin
                    state_nxt = S_IDLE;
                end else begin
                    ch_nxt   = ch + 3'd1;
                    wr_nxt   = 1'b1;
                    addr_nxt = ch_base(ch_nxt);
                    data_nxt = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (scan_go && (cur[scan_k] != tgt[scan_k])) begin
            cur_upd  = 1'b1;
            cur_val  = ramp(cur[scan_k], tgt[scan_k]);
            wr_nxt   = 1'b1;
            addr_nxt = ch_base(scan_k) + 32'd4;
            data_nxt = cur_val;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= S_IDLE;
            ch        <= '0;
            sub       <= '0;
            presc     <= '0;
            stop_pend <= 1'b0;
            pwm_wr    <= 1'b0;
            pwm_addr  <= '0;
            pwm_data  <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            sub       <= sub_nxt;
            presc     <= presc_nxt;
            stop_pend <= stop_pend_nxt;
            pwm_wr    <= wr_nxt;
            pwm_addr  <= addr_nxt;
            pwm_data  <= data_nxt;
            busy      <= (state_nxt == S_INIT) || (state_nxt == S_SCAN) || (state_nxt == S_DIS);
            cmd_ready <= (state_nxt == S_IDLE) || (state_nxt == S_RUN) || (state_nxt == S_SCAN);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int unsigned i = 0; i < 8; i++) begin
                cur[i[2:0]] <= DUTY_RST;
                tgt[i[2:0]] <= DUTY_RST;
            end
            settled <= '1;
        end else begin
            if (cur_upd) cur[scan_k] <= cur_val;
            if (cmd_fire) tgt[cmd_ch] <= clamp(cmd_target);
            for (int unsigned i = 0; i < 8; i++) begin
                settled[i[2:0]] <= (cur[i[2:0]] == tgt[i[2:0]]);
            end
        end
    end

endmodule
